// File: rtl/mult_controller_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared types and constants for the sum-and-shift multiplier controller.
//   state_t    : controller FSM state encoding (3 bits, codes 6/7 unused)
//   MULT_SIZE  : default operand width / iteration count
//   cnt_w()    : width of a counter able to hold 0..size inclusive
// -----------------------------------------------------------------------------
package mult_pkg;

  localparam int MULT_SIZE = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic int cnt_w(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/mult_controller_if.sv
// -----------------------------------------------------------------------------
// mult_controller_if
// Bundles the request/handshake inputs and the datapath strobes of the
// multiplier controller.
//   start, q0                    : requester / datapath -> controller
//   load_en, clear (active-low),
//   add_en, shift_en             : controller -> datapath registers
//   busy, done, count            : controller status
// Modports: master = requester/datapath side, slave = controller side.
// -----------------------------------------------------------------------------
interface mult_controller_if #(
  parameter int size = mult_pkg::MULT_SIZE
);

  localparam int CW = mult_pkg::cnt_w(size);

  logic          start;
  logic          q0;
  logic          load_en;
  logic          clear;
  logic          add_en;
  logic          shift_en;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;

  modport master (
    output start, q0,
    input  load_en, clear, add_en, shift_en, busy, done, count
  );

  modport slave (
    input  start, q0,
    output load_en, clear, add_en, shift_en, busy, done, count
  );

endinterface

// File: rtl/mult_controller_bit_counter.sv
// -----------------------------------------------------------------------------
// bit_counter
// Counts multiplier bits already processed.
//   clk      : system clock
//   reset    : asynchronous active-low reset (count -> 0)
//   clr_i    : synchronous clear (takes priority over inc_i)
//   inc_i    : increment by one, saturating at size
//   count_o  : current count
//   term_o   : count == size-1, i.e. the bit under test is the last one
// -----------------------------------------------------------------------------
module bit_counter
  import mult_pkg::*;
#(
  parameter int size  = MULT_SIZE,
  parameter int WIDTH = cnt_w(size)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             term_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(size - 1);
  localparam logic [WIDTH-1:0] MAX  = WIDTH'(size);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MAX)) begin
      // Saturate so the count can only wrap by being reloaded.
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign term_o  = (count_q == LAST);

endmodule

// File: rtl/mult_controller.sv
// -----------------------------------------------------------------------------
// mult_controller
// Sequencing FSM for the sum-and-shift multiplier. Runs one multiply per
// start request, walking the multiplier LSB-first: LOAD, then for every bit
// TEST -> (ADD if q0) -> SHIFT, then DONE until start is released.
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : mult_controller_if.slave
//            in : start (level request), q0 (multiplier LSB)
//            out: load_en, clear (active-low), add_en, shift_en,
//                 busy, done, count
// All strobes are a Moore decode of the state register, so they never
// glitch on q0.
// -----------------------------------------------------------------------------
module mult_controller
  import mult_pkg::*;
#(
  parameter int size = MULT_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  mult_controller_if.slave      bus
);

  localparam int CW = cnt_w(size);

  state_t        state_q;
  state_t        state_d;

  logic          cnt_clr;
  logic          cnt_inc;
  logic          cnt_term;
  logic [CW-1:0] cnt_val;

  logic          load_en;
  logic          clear;
  logic          add_en;
  logic          shift_en;
  logic          busy;
  logic          done;

  // ---------------------------------------------------------------------------
  // Bit counter: reloaded to 0 when leaving LOAD, advanced on every SHIFT.
  // ---------------------------------------------------------------------------
  assign cnt_clr = (state_q == LOAD);
  assign cnt_inc = (state_q == SHIFT);

  bit_counter #(
    .size  (size),
    .WIDTH (CW)
  ) u_bit_counter (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .count_o (cnt_val),
    .term_o  (cnt_term)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. start matters only in IDLE and DONE; unused encodings
  // fall through to IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = bus.start ? LOAD : IDLE;
      LOAD:    state_d = TEST;
      TEST:    state_d = bus.q0 ? ADD : SHIFT;
      ADD:     state_d = SHIFT;
      SHIFT:   state_d = cnt_term ? DONE : TEST;
      // Holding start keeps us here, so a held request never retriggers.
      DONE:    state_d = bus.start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (state register only)
  // ---------------------------------------------------------------------------
  always_comb begin
    load_en  = 1'b0;
    clear    = 1'b1;
    add_en   = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      LOAD: begin
        load_en = 1'b1;
        clear   = 1'b0;
        busy    = 1'b1;
      end
      TEST: begin
        busy = 1'b1;
      end
      ADD: begin
        add_en = 1'b1;
        busy   = 1'b1;
      end
      SHIFT: begin
        shift_en = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.load_en  = load_en;
  assign bus.clear    = clear;
  assign bus.add_en   = add_en;
  assign bus.shift_en = shift_en;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.count    = cnt_val;

  // ---------------------------------------------------------------------------
  // Embedded checks
  // ---------------------------------------------------------------------------
  a_strobe_onehot0 : assert property (
    @(posedge clk) disable iff (!reset)
      $onehot0({load_en, add_en, shift_en})
  );

  a_last_shift_done : assert property (
    @(posedge clk) disable iff (!reset)
      (state_q == SHIFT && cnt_term) |=> done
  );

  a_done_not_busy : assert property (
    @(posedge clk) disable iff (!reset)
      done |-> !busy
  );

endmodule

// File: tb/tb_mult_controller.sv
// -----------------------------------------------------------------------------
// tb_mult_controller
// Directed and randomized multiplies. The expected per-cycle output trace is
// built from the multiplier value: LOAD, then per bit TEST, ADD (bit set),
// SHIFT, then DONE; q0 is driven from the multiplier bit currently under
// test.
// -----------------------------------------------------------------------------
module tb_mult_controller;

  localparam int SIZE = 8;
  localparam int CW   = mult_pkg::cnt_w(SIZE);
  localparam int VW   = 6 + CW;

  typedef struct {
    logic [VW-1:0] v;
    int            bitn;
  } step_t;

  logic clk;
  logic reset;

  int total;
  int bad;
  int prev_cnt;

  mult_controller_if #(.size(SIZE)) bus ();

  mult_controller #(.size(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {load_en, clear, add_en, shift_en, busy, done, count}
  function automatic logic [VW-1:0] ev(input logic ld, input logic cl,
                                       input logic ad, input logic sh,
                                       input logic bs, input logic dn,
                                       input int cnt);
    logic [CW-1:0] c;
    c = CW'(cnt);
    return {ld, cl, ad, sh, bs, dn, c};
  endfunction

  function automatic logic [VW-1:0] obs();
    return {bus.load_en, bus.clear, bus.add_en, bus.shift_en,
            bus.busy, bus.done, bus.count};
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] got,
                     input logic [VW-1:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // One complete multiply. toggle: randomize start while busy.
  // hold: cycles to keep start high once DONE is reached.
  task automatic run(input logic [SIZE-1:0] m, input bit toggle, input int hold);
    step_t q[$];
    int    pop;
    pop = 0;
    q.push_back('{ev(1, 0, 0, 0, 1, 0, prev_cnt), 0});
    for (int k = 0; k < SIZE; k++) begin
      q.push_back('{ev(0, 1, 0, 0, 1, 0, k), k});
      if (m[k]) begin
        q.push_back('{ev(0, 1, 1, 0, 1, 0, k), k});
        pop++;
      end
      q.push_back('{ev(0, 1, 0, 1, 1, 0, k), k});
    end
    q.push_back('{ev(0, 1, 0, 0, 0, 1, SIZE), 0});

    @(negedge clk);
    bus.start = 1'b1;
    bus.q0    = 1'($urandom_range(0, 1));
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("m=%h step%0d", m, i), obs(), q[i].v);
      if (i != q.size() - 1) begin
        bus.q0    = m[q[i].bitn];
        bus.start = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    bus.start = (hold > 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk($sformatf("m=%h hold%0d", m, h), obs(), ev(0, 1, 0, 0, 0, 1, SIZE));
    end
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk($sformatf("m=%h idle", m), obs(), ev(0, 1, 0, 0, 0, 0, SIZE));
    prev_cnt = SIZE;
    $display("txn m=%h pop=%0d latency=%0d toggle=%0d hold=%0d", m, pop,
             1 + 2 * SIZE + pop, toggle, hold);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    prev_cnt  = 0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.q0    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", obs(), ev(0, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_idle", obs(), ev(0, 1, 0, 0, 0, 0, 0));

    // Boundary multipliers and a mixed pattern
    run(8'h00, 1'b0, 0);
    run(8'hFF, 1'b0, 0);
    run(8'hA5, 1'b0, 0);

    // Held start: DONE persists, no reload; then retrigger right away
    run(8'h3C, 1'b0, 5);
    run(8'h81, 1'b0, 0);

    // Reset during ADD: asynchronous return to reset values
    @(negedge clk);
    bus.start = 1'b1;
    bus.q0    = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_load", obs(), ev(1, 0, 0, 0, 1, 0, prev_cnt));
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_test", obs(), ev(0, 1, 0, 0, 1, 0, 0));
    @(posedge clk);
    #1;
    chk("abort_add", obs(), ev(0, 1, 1, 0, 1, 0, 0));
    #2;
    reset = 1'b0;
    #1;
    chk("abort_async", obs(), ev(0, 1, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    prev_cnt = 0;
    @(posedge clk);
    #1;
    chk("abort_idle", obs(), ev(0, 1, 0, 0, 0, 0, 0));
    $display("txn reset_mid_add checked");
    run(8'h5A, 1'b0, 0);

    // Randomized multipliers with start toggling while busy
    for (int r = 0; r < 8; r++) begin
      run(SIZE'($urandom), 1'b1, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
